shift_memory_sync: RTL and testbench
====================================

Name: shift_memory_sync

Overview:
Synchronous, parametrised successor to the asynchronous pulse-driven word memory.
- Register file of 2**Addr_width words of Data_width bits.
- Supports write, read and a multi-position in-place shift/rotate of one word, executed one bit-position per clock.
- Sits between the control FSM and the datapath; the former bidirectional DATA bus is split into DIN/DOUT, and command completion is signalled by BUSY/VALID/ERR.

Parameters:
Addr_width, 3, address bits; depth = 2**Addr_width words
Data_width, 8, bits per word
Shift_width, 3, width of the shift-amount port SA; maximum shift 2**Shift_width-1

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
CS  input  1  chip select; PW/PR/PS ignored while low
PW  input  1  write command
PR  input  1  read command
PS  input  1  shift command
SD  input  1  shift direction: 1 = left (toward MSB), 0 = right
SV  input  1  fill bit shifted in when ROT=0
ROT  input  1  1 = rotate (bit shifted out re-enters); SV ignored
SA  input  Shift_width  number of positions to shift
ADDR  input  Addr_width  word address
DIN  input  Data_width  write data
DOUT  output  Data_width  read/shift result
VALID  output  1  one-cycle pulse: DOUT holds new result
BUSY  output  1  shift in progress
ERR  output  1  one-cycle pulse: command rejected

Behaviour:
- Reset (RST_N low, asynchronous): every word = 0, DOUT = 0, VALID = 0, BUSY = 0, ERR = 0, state = IDLE, counter = 0. Reset mid-shift aborts the shift; the word under shift reads 0 afterwards like all others.
- Commands are sampled on the rising edge only when CS = 1; with CS = 0 no command is accepted and ERR stays 0.
- Command error: more than one of PW/PR/PS high while CS = 1 → no action, ERR = 1 the next cycle.
- Any command while BUSY = 1 → ignored, ERR = 1 the next cycle. The running shift is unaffected.
- FSM states: IDLE, SHIFT (CLEAR only with the optional feature).
- IDLE + PW: mem[ADDR] <= DIN at that edge. No VALID, no BUSY. A read of the same address in the next cycle returns the new data.
- IDLE + PR: DOUT <= mem[ADDR] at that edge; VALID = 1 for exactly one cycle (latency 1).
- IDLE + PS with SA = 0: no change; DOUT <= mem[ADDR], VALID pulse next cycle.
- IDLE + PS with SA > 0:
  - Latch ADDR, SD, SV, ROT; counter <= SA; BUSY = 1 from the next cycle; go to SHIFT.
- SHIFT, each cycle:
  - Shift the latched word one position in direction SD. Fill with SV, or with the ejected bit when ROT = 1.
  - Decrement counter.
  - When counter reaches 1, that cycle's shift is the last. On that edge: DOUT <= result, VALID = 1, BUSY = 0, go to IDLE.
- Total shift latency = SA cycles from the accepting edge to the VALID pulse. BUSY is high for SA cycles.
- SA ≥ Data_width with ROT = 0: result is all SV. With ROT = 1: the word is rotated by SA mod Data_width.
- DOUT holds its last value between results. VALID is never high together with ERR for the same command.
- Inputs SD/SV/ROT/ADDR changing during SHIFT have no effect.

Optional Feature:
MEM_CLR_EN
- Defined:
  - CS = 1 with PW and PS both high (otherwise an error combination) is a CLEAR command.
  - In IDLE, CLEAR enters state CLEAR; BUSY = 1 for 2**Addr_width cycles, zeroing one word per cycle from address 0 upward.
  - At completion: VALID pulse, DOUT unchanged, return to IDLE.
  - Commands during CLEAR → ERR.
- Undefined: PW+PS together is an ordinary error (ERR pulse); the CLEAR state and its logic are absent.

Test Plan:
- Reset, then PR at ADDR=5 → DOUT = 8'h00, VALID one cycle later, ERR = 0.
- PW ADDR=1, DIN=8'b00001111; next cycle PR ADDR=1 → DOUT = 8'b00001111, VALID pulse 1 cycle after the read.
- mem[1] = 8'b00001111; PS with SD=1, SV=1, ROT=0, SA=3 → BUSY high for 3 cycles, then VALID with DOUT = 8'b01111111; PR ADDR=1 confirms.
- mem[2] = 8'b10000001; PS with SD=0, ROT=1, SA=1 → DOUT = 8'b11000000. Repeat with SA=7, ROT=0, SV=0 → DOUT = 8'b00000001.
- During a shift with SA=5, issue PR → ERR pulse, shift completes unchanged. PW+PR together in IDLE → ERR, memory unchanged.
- Assert RST_N low mid-shift → BUSY/VALID/DOUT 0 immediately; after release PR → 8'h00. With MEM_CLR_EN: CLEAR after writes → BUSY 8 cycles, all words read 0.

Source files
------------

// File: rtl/shift_memory_sync.sv
// Word register file with write, read and a multi-cycle shift/rotate of one word in place.
// Latency: read 1 cycle, shift SA cycles (one bit-position per clock); optional `MEM_CLR_EN adds a 2**Addr_width-cycle CLEAR.
// Backpressure: BUSY high while a shift/clear runs; any command then, or an illegal combination, is dropped with a 1-cycle ERR.
module shift_memory_sync #(
    parameter int Addr_width  = 3,
    parameter int Data_width  = 8,
    parameter int Shift_width = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CS,
    input  logic                  PW,
    input  logic                  PR,
    input  logic                  PS,
    input  logic                  SD,
    input  logic                  SV,
    input  logic                  ROT,
    input  logic [Shift_width-1:0] SA,
    input  logic [Addr_width-1:0] ADDR,
    input  logic [Data_width-1:0] DIN,
    output logic [Data_width-1:0] DOUT,
    output logic                  VALID,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int Depth = 1 << Addr_width;

`ifdef MEM_CLR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CLEAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t                state, state_nxt;
    logic [Data_width-1:0] mem [0:Depth-1];
    logic [Shift_width-1:0] cnt;
    logic [Addr_width-1:0] sh_addr;
    logic                  sh_dir, sh_fill, sh_rot;
    logic [Data_width-1:0] sh_word;

    logic cmd_any, cmd_multi, cmd_err;
    logic wr_acc, rd_acc, ps_acc, ps_go, ps_now, sh_last;
`ifdef MEM_CLR_EN
    logic [Addr_width-1:0] clr_addr;
    logic                  clr_cmd, clr_acc, clr_last;
`endif

    function automatic logic [Data_width-1:0] shift1(input logic [Data_width-1:0] w,
                                                     input logic dir, input logic fill_v,
                                                     input logic rot);
        logic f;
        f = fill_v;
        if (dir) begin
            if (rot) f = w[Data_width-1];
            return {w[Data_width-2:0], f};
        end else begin
            if (rot) f = w[0];
            return {f, w[Data_width-1:1]};
        end
    endfunction

    // Command decode; PW+PS is only legal when the clear feature is built in
    always_comb begin
        cmd_any   = CS & (PW | PR | PS);
        cmd_multi = (PW & PR) | (PW & PS) | (PR & PS);
`ifdef MEM_CLR_EN
        clr_cmd   = CS & PW & PS & ~PR;
        cmd_err   = cmd_any & (BUSY | (cmd_multi & ~clr_cmd));
        clr_acc   = clr_cmd & ~BUSY;
        clr_last  = (clr_addr == Addr_width'(Depth - 1));
`else
        cmd_err   = cmd_any & (BUSY | cmd_multi);
`endif
        wr_acc  = cmd_any & ~cmd_err & ~cmd_multi & PW;
        rd_acc  = cmd_any & ~cmd_err & ~cmd_multi & PR;
        ps_acc  = cmd_any & ~cmd_err & ~cmd_multi & PS;
        ps_go   = ps_acc & (SA != '0);
        ps_now  = ps_acc & (SA == '0);
        sh_last = (state == SHIFT) && (cnt == Shift_width'(1));
        sh_word = shift1(mem[sh_addr], sh_dir, sh_fill, sh_rot);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ps_go) state_nxt = SHIFT;
`ifdef MEM_CLR_EN
                if (clr_acc) state_nxt = CLEAR;
`endif
            end
            SHIFT: if (sh_last) state_nxt = IDLE;
`ifdef MEM_CLR_EN
            CLEAR: if (clr_last) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != IDLE);
    end

    // Storage: writes, in-place shift steps and clear sweep never coincide
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else begin
            if (wr_acc) mem[ADDR] <= DIN;
            if (state == SHIFT) mem[sh_addr] <= sh_word;
`ifdef MEM_CLR_EN
            if (state == CLEAR) mem[clr_addr] <= '0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DOUT    <= '0;
            VALID   <= 1'b0;
            ERR     <= 1'b0;
            cnt     <= '0;
            sh_addr <= '0;
            sh_dir  <= 1'b0;
            sh_fill <= 1'b0;
            sh_rot  <= 1'b0;
`ifdef MEM_CLR_EN
            clr_addr <= '0;
`endif
        end else begin
            VALID <= 1'b0;
            ERR   <= cmd_err;
            if (rd_acc || ps_now) begin
                DOUT  <= mem[ADDR];
                VALID <= 1'b1;
            end
            if (ps_go) begin
                cnt     <= SA;
                sh_addr <= ADDR;
                sh_dir  <= SD;
                sh_fill <= SV;
                sh_rot  <= ROT;
            end
            if (state == SHIFT) begin
                cnt <= cnt - Shift_width'(1);
                if (sh_last) begin
                    DOUT  <= sh_word;
                    VALID <= 1'b1;
                end
            end
`ifdef MEM_CLR_EN
            if (clr_acc) clr_addr <= '0;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + Addr_width'(1);
                if (clr_last) VALID <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_shift_memory_sync.sv
// Scoreboard bench for shift_memory_sync: stimulus pushes expected VALID data / ERR tokens,
// a monitor on the falling edge pops and compares whenever the DUT presents a result.
module tb_shift_memory_sync;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CS = 1'b0, PW = 1'b0, PR = 1'b0, PS = 1'b0;
    logic       SD = 1'b0, SV = 1'b0, ROT = 1'b0;
    logic [2:0] SA = '0;
    logic [2:0] ADDR = '0;
    logic [7:0] DIN = '0;
    logic [7:0] DOUT;
    logic       VALID, BUSY, ERR;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q_dout[$];
    int         q_err[$];
    int         nbusy;

    shift_memory_sync #(.Addr_width(3), .Data_width(8), .Shift_width(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .PW(PW), .PR(PR), .PS(PS),
        .SD(SD), .SV(SV), .ROT(ROT), .SA(SA), .ADDR(ADDR), .DIN(DIN),
        .DOUT(DOUT), .VALID(VALID), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every VALID pops a data expectation, every ERR pops an error token
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                if (VALID) begin
                    if (q_dout.size() == 0) begin
                        check("unexpected_valid", 8'd1, 8'd0);
                    end else begin
                        e = q_dout.pop_front();
                        check("dout", DOUT, e);
                    end
                end
                if (ERR) begin
                    if (q_err.size() == 0) check("unexpected_err", 8'd1, 8'd0);
                    else begin
                        void'(q_err.pop_front());
                        check("err_pulse", 8'd1, 8'd1 & {7'd0, ERR});
                    end
                end
            end
        end
    end

    task automatic cmd(input logic cs, input logic pw, input logic pr, input logic ps,
                       input logic [2:0] addr, input logic [7:0] din, input logic [2:0] sa,
                       input logic sd, input logic sv, input logic rot);
        CS = cs; PW = pw; PR = pr; PS = ps; ADDR = addr; DIN = din;
        SA = sa; SD = sd; SV = sv; ROT = rot;
        @(posedge CLK); #1;
        CS = 1'b0; PW = 1'b0; PR = 1'b0; PS = 1'b0;
        ADDR = $urandom_range(7); SD = $urandom_range(1); SV = $urandom_range(1); ROT = $urandom_range(1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cmd(1, 1, 0, 0, a, d, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp);
        q_dout.push_back(exp);
        cmd(1, 0, 1, 0, a, 8'h00, 0, 0, 0, 0);
    endtask

    // Counts falling edges with BUSY high, bounded so a stuck BUSY cannot hang the run
    task automatic wait_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (!BUSY) break;
            n++;
        end
    endtask

    initial begin
        #12 RST_N = 1'b1;
        @(posedge CLK); #1;
        check("reset_busy", {7'd0, BUSY}, 8'd0);
        check("reset_valid", {7'd0, VALID}, 8'd0);
        check("reset_err", {7'd0, ERR}, 8'd0);
        check("reset_dout", DOUT, 8'h00);

        rd(3'd5, 8'h00);
        wr(3'd1, 8'b0000_1111);
        rd(3'd1, 8'b0000_1111);

        // Left shift by 3 filling ones
        q_dout.push_back(8'b0111_1111);
        cmd(1, 0, 0, 1, 3'd1, 0, 3'd3, 1, 1, 0);
        wait_busy(nbusy);
        check("busy_sa3", 8'(nbusy), 8'd3);
        rd(3'd1, 8'b0111_1111);

        // Right rotate by 1, then right shift by 7 filling zeros
        wr(3'd2, 8'b1000_0001);
        q_dout.push_back(8'b1100_0000);
        cmd(1, 0, 0, 1, 3'd2, 0, 3'd1, 0, 0, 1);
        wait_busy(nbusy);
        check("busy_sa1", 8'(nbusy), 8'd1);
        wr(3'd2, 8'b1000_0001);
        q_dout.push_back(8'b0000_0001);
        cmd(1, 0, 0, 1, 3'd2, 0, 3'd7, 0, 0, 0);
        wait_busy(nbusy);
        check("busy_sa7", 8'(nbusy), 8'd7);

        // Left rotate 0xA5 by 5 with a read attempted while busy
        wr(3'd3, 8'hA5);
        q_dout.push_back(8'hB4);
        cmd(1, 0, 0, 1, 3'd3, 0, 3'd5, 1, 0, 1);
        q_err.push_back(1);
        cmd(1, 0, 1, 0, 3'd3, 0, 0, 0, 0, 0);
        wait_busy(nbusy);
        check("busy_sa5_rest", 8'(nbusy), 8'd4);

        // Illegal combinations leave memory untouched
        q_err.push_back(1);
        cmd(1, 1, 1, 0, 3'd3, 8'hFF, 0, 0, 0, 0);
        q_err.push_back(1);
        cmd(1, 0, 1, 1, 3'd3, 8'hFF, 3'd2, 0, 0, 0);
        q_err.push_back(1);
        cmd(1, 1, 1, 1, 3'd3, 8'hFF, 3'd2, 0, 0, 0);
`ifndef MEM_CLR_EN
        q_err.push_back(1);
        cmd(1, 1, 0, 1, 3'd3, 8'hFF, 3'd2, 0, 0, 0);
`endif
        rd(3'd3, 8'hB4);

        // Zero-length shift reports the word immediately
        q_dout.push_back(8'hB4);
        cmd(1, 0, 0, 1, 3'd3, 0, 3'd0, 1, 1, 0);
        // Chip select low: nothing accepted
        cmd(0, 0, 1, 0, 3'd3, 0, 0, 0, 0, 0);
        cmd(0, 1, 0, 0, 3'd3, 8'h11, 0, 0, 0, 0);
        q_dout.push_back(8'h7F);
        cmd(1, 0, 0, 1, 3'd3, 0, 3'd7, 1, 1, 0);
        wait_busy(nbusy);
        check("busy_sa7_fill1", 8'(nbusy), 8'd7);
        rd(3'd3, 8'h7F);

`ifdef MEM_CLR_EN
        wr(3'd0, 8'h5A);
        wr(3'd7, 8'hC3);
        q_dout.push_back(8'h7F);
        cmd(1, 1, 0, 1, 3'd0, 0, 0, 0, 0, 0);
        q_err.push_back(1);
        cmd(1, 0, 1, 0, 3'd0, 0, 0, 0, 0, 0);
        wait_busy(nbusy);
        check("busy_clear", 8'(nbusy), 8'd7);
        for (int a = 0; a < 8; a++) rd(3'(a), 8'h00);
        wr(3'd1, 8'h0F);
`endif

        // Reset in the middle of a shift aborts it; DOUT was non-zero before
        cmd(1, 0, 0, 1, 3'd1, 0, 3'd5, 1, 0, 1);
        @(negedge CLK); @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_busy", {7'd0, BUSY}, 8'd0);
        check("midrst_valid", {7'd0, VALID}, 8'd0);
        check("midrst_dout", DOUT, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        rd(3'd1, 8'h00);
        rd(3'd3, 8'h00);

        repeat (5) @(negedge CLK);
        check("pending_valid", 8'(q_dout.size()), 8'd0);
        check("pending_err", 8'(q_err.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
